// File: rtl/cache_control_if.sv
// Bundle of CPU request, datapath status, physical-memory handshake and
// datapath load strobes shared between the cache controller and its environment.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic valid_in;
  logic dirty_in;
  logic tag_match;
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  logic data_load;
  logic data_sel;
  logic tag_load;
  logic valid_load;
  logic dirty_load;
  logic dirty_value;

  modport master (
    output mem_read, mem_write, valid_in, dirty_in, tag_match, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_load,
           data_sel, tag_load, valid_load, dirty_load, dirty_value
  );

  modport slave (
    input  mem_read, mem_write, valid_in, dirty_in, tag_match, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_load,
           data_sel, tag_load, valid_load, dirty_load, dirty_value
  );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a direct-mapped L1 cache: hit handling, write-back and
// line-fill sequencing, plus saturating hit/miss/write-back event counters.
module cache_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_control_if.slave         bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count,
  output logic [COUNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   retry_q, retry_d;
  logic [COUNT_WIDTH-1:0] hit_q, miss_q, wb_q;
  logic                   hit_inc, miss_inc, wb_inc;
  logic                   req, hit;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    if (en && (v != {COUNT_WIDTH{1'b1}})) return v + COUNT_WIDTH'(1);
    return v;
  endfunction

  // A simultaneous read and write is handled as a write.
  assign req = bus.mem_read | bus.mem_write;
  assign hit = bus.valid_in & bus.tag_match;

  always_comb begin
    state_d           = state_q;
    retry_d           = retry_q;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    wb_inc            = 1'b0;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.data_load     = 1'b0;
    bus.data_sel      = 1'b0;
    bus.tag_load      = 1'b0;
    bus.valid_load    = 1'b0;
    bus.dirty_load    = 1'b0;
    bus.dirty_value   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        retry_d = 1'b0;
        if (req) begin
          if (hit) begin
            bus.mem_resp = 1'b1;
            hit_inc      = ~retry_q;
            if (bus.mem_write) begin
              bus.data_load   = 1'b1;
              bus.dirty_load  = 1'b1;
              bus.dirty_value = 1'b1;
            end
          end else begin
            miss_inc = 1'b1;
            if (bus.valid_in && bus.dirty_in) begin
              wb_inc  = 1'b1;
              state_d = S_WRITEBACK;
            end else begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        bus.pmem_read = 1'b1;
        // The filled line is written clean; a pending write re-dirties it on retry.
        if (bus.pmem_resp) begin
          bus.data_load  = 1'b1;
          bus.data_sel   = 1'b1;
          bus.tag_load   = 1'b1;
          bus.valid_load = 1'b1;
          bus.dirty_load = 1'b1;
          retry_d        = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      retry_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      hit_q   <= sat_inc(hit_q, hit_inc);
      miss_q  <= sat_inc(miss_q, miss_inc);
      wb_q    <= sat_inc(wb_q, wb_inc);
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;

endmodule
